// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the sequential ALU.
//   op_e    : 4-bit opcode encodings carried on the sel input (14/15 reserved)
//   state_e : sequencer states (IDLE, BUSY, HOLD)
//   flags_t : flag bundle produced by the combinational core
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SHL  = 4'd2,
    OP_SHR  = 4'd3,
    OP_ROL  = 4'd4,
    OP_ROR  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_NOT  = 4'd8,
    OP_NAND = 4'd9,
    OP_XOR  = 4'd10,
    OP_XNOR = 4'd11,
    OP_NOR  = 4'd12,
    OP_MUL  = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic carry_out;
    logic zero;
    logic overflow;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core -- combinational datapath for every single-cycle opcode.
//   a, b      : operands (WIDTH bits)
//   sel       : opcode (alu_pkg::op_e encoding)
//   carry_in  : carry for ADD, borrow for SUB
//   result    : low-word result
//   flags     : carry_out / zero / overflow / err
// MUL is sequenced by the parent; here it yields a zero result with err 0.
// Reserved opcodes yield result 0, zero 1, err 1.
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  // One extra bit catches the carry (ADD) or the borrow (SUB, wraps negative).
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would otherwise infer a latch.
    result = '0;
    flags  = '0;
    case (sel)
      OP_ADD: begin
        result          = sum[MSB:0];
        flags.carry_out = sum[WIDTH];
        // Like-signed operands producing an opposite-signed sum.
        flags.overflow  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result          = diff[MSB:0];
        flags.carry_out = diff[WIDTH];
        // Unlike-signed operands whose difference takes the subtrahend's sign.
        flags.overflow  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SHL: begin
        result          = {a[MSB-1:0], 1'b0};
        flags.carry_out = a[MSB];
      end
      OP_SHR: begin
        result          = {1'b0, a[MSB:1]};
        flags.carry_out = a[0];
      end
      OP_ROL: begin
        result          = {a[MSB-1:0], a[MSB]};
        flags.carry_out = a[MSB];
      end
      OP_ROR: begin
        result          = {a[0], a[MSB:1]};
        flags.carry_out = a[0];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      OP_NAND: result = ~(a & b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NOR:  result = ~(a | b);
      OP_MUL:  result = '0;
      default: flags.err = 1'b1;
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- valid/ready wrapped ALU with an iterative shift-add multiplier.
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake (A, B, sel, carry_in)
//   out_valid, out_ready: result handshake
//   result, result_hi   : low word, high word (MUL only, else 0)
//   carry_out, zero, overflow, err : registered result flags
// Single-cycle ops appear the edge they are accepted; MUL takes WIDTH edges.
// A held result may be replaced on the same edge it is consumed.
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state;
  logic               accept;
  logic [WIDTH-1:0]   core_result;
  flags_t             core_flags;

  // Multiplier: acc holds {partial product, remaining multiplier bits}.
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] acc_next;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (A),
    .b        (B),
    .sel      (sel),
    .carry_in (carry_in),
    .result   (core_result),
    .flags    (core_flags)
  );

  // A held result can be consumed and replaced on the same edge.
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // One multiplier bit per cycle: conditionally add, then shift right with
  // the carry of the add entering at the top.
  assign addend   = acc[0] ? mcand : '0;
  assign hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_next = {hi_sum, acc[WIDTH-1:1]};

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
      // NOTE: the multiplier registers are cleared too, so an aborted MUL
      // leaves no residue that could leak into a later product.
      mcand     <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (sel == OP_MUL) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              mcand     <= A;
              acc       <= {{WIDTH{1'b0}}, B};
              count     <= '0;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              result    <= core_result;
              result_hi <= '0;
              carry_out <= core_flags.carry_out;
              zero      <= core_flags.zero;
              overflow  <= core_flags.overflow;
              err       <= core_flags.err;
            end
          end else if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        BUSY: begin
          acc   <= acc_next;
          count <= count + CNT_W'(1);
          if (count == LAST_STEP) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            result    <= acc_next[WIDTH-1:0];
            result_hi <= acc_next[2*WIDTH-1:WIDTH];
            carry_out <= (acc_next[2*WIDTH-1:WIDTH] != '0);
            zero      <= (acc_next[WIDTH-1:0] == '0);
            overflow  <= 1'b0;
            err       <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
